// File: rtl/irq_pkg.sv
// Shared types and constants for the irq_ctrl interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } irq_state_t;

  localparam logic [1:0] CFG_MASK    = 2'd0;
  localparam logic [1:0] CFG_CLRPEND = 2'd1;
  localparam logic [1:0] CFG_EOI     = 2'd2;

  localparam int DEF_N_SRC = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder: first set bit of elig, searching upward from start and
// wrapping. A start of 0 gives plain fixed priority (index 0 highest).
module irq_prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] elig,
  input  logic [ID_W-1:0]  start,
  output logic             found,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    int idx;
    logic [ID_W-1:0] idx_v;
    idx   = 0;
    idx_v = '0;
    found = 1'b0;
    id    = '0;
    // Walk from the farthest offset down so the nearest hit is the last write.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      idx_v = ID_W'(idx);
      if (elig[idx_v]) begin
        found = 1'b1;
        id    = idx_v;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-latching interrupt controller driving the core's ExtIRQ/ExtIAck pair.
// Build option: define IRQ_ROUND_ROBIN_EN for rotating arbitration.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N     = 64,
  parameter int N_SRC = DEF_N_SRC,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N-1:0]     cfg_wdata,
  output logic             ExtIRQ,
  input  logic             ExtIAck,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic [1:0]       fsm_state
);

  // Handshake: ExtIRQ is held high in REQ until ExtIAck is sampled high on a
  // rising edge; that edge completes the transfer and ExtIRQ drops after it.

  irq_state_t       state_q, state_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic             ext_irq_q;
  logic [N_SRC-1:0] prev_q, pending_q, pending_d, mask_q;
  logic [N_SRC-1:0] rise, elig, clr_v, ack_onehot;
  logic             wr_mask, wr_clr, wr_eoi, ack_fire;
  logic             win_found;
  logic [ID_W-1:0]  win_id, start_idx;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata[N-1:N_SRC];

  assign wr_mask  = cfg_we && (cfg_addr == CFG_MASK);
  assign wr_clr   = cfg_we && (cfg_addr == CFG_CLRPEND);
  assign wr_eoi   = cfg_we && (cfg_addr == CFG_EOI);
  assign ack_fire = (state_q == ST_REQ) && ExtIAck;

  assign rise       = irq_src & ~prev_q;
  assign elig       = pending_q & mask_q;
  assign ack_onehot = N_SRC'(1) << cur_id_q;
  assign clr_v      = (wr_clr ? cfg_wdata[N_SRC-1:0] : '0) | (ack_fire ? ack_onehot : '0);
  // New edges are OR-ed in last so a same-cycle set beats any clear.
  assign pending_d  = (pending_q & ~clr_v) | rise;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else if (ack_fire) begin
      rr_ptr_q <= (int'(cur_id_q) == N_SRC - 1) ? '0 : cur_id_q + 1'b1;
    end
  end

  assign start_idx = rr_ptr_q;
`else
  assign start_idx = '0;
`endif

  irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio (
    .elig  (elig),
    .start (start_idx),
    .found (win_found),
    .id    (win_id)
  );

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          cur_id_d = win_id;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ExtIAck)               state_d = ST_ACTIVE;
        else if (!mask_q[cur_id_q]) state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (wr_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cur_id_q  <= '0;
      ext_irq_q <= 1'b0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      ext_irq_q <= (state_d == ST_REQ);
      prev_q    <= irq_src;
      pending_q <= pending_d;
      if (wr_mask) mask_q <= cfg_wdata[N_SRC-1:0];
    end
  end

  assign ExtIRQ    = ext_irq_q;
  assign irq_id    = cur_id_q;
  assign pending   = pending_q;
  assign mask      = mask_q;
  assign fsm_state = state_q;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller in front of the single-cycle LEGv8 `processor_arm` core. It latches edge-triggered requests from up to `N_SRC` peripheral sources and masks them through a small write-only configuration port. It selects one winner and drives the core's single `ExtIRQ` line, completing the `ExtIRQ`/`ExtIAck` handshake. It holds the serviced source ID stable until the handler writes end-of-interrupt (EOI).

## Interface
- `N` — 64 — configuration write-data width; matches the core data width.
- `N_SRC` — 4 — number of interrupt sources, 2..16.
- `ID_W` — `$clog2(N_SRC)` — width of the source ID.

- `CLOCK_50` — in — 1 — system clock; all state updates on the rising edge.
- `reset` — in — 1 — asynchronous, active-low reset.
- `irq_src` — in — `N_SRC` — raw requests, synchronous to `CLOCK_50`; each rising edge is an event.
- `cfg_we` — in — 1 — configuration write strobe, one cycle per write.
- `cfg_addr` — in — 2 — register select: 0 = MASK, 1 = CLRPEND, 2 = EOI, 3 = reserved (write ignored).
- `cfg_wdata` — in — `N` — write data; only bits `[N_SRC-1:0]` are used.
- `ExtIRQ` — out — 1 — interrupt request to the core.
- `ExtIAck` — in — 1 — acknowledge from the core.
- `irq_id` — out — `ID_W` — ID of the source being requested or serviced.
- `pending` — out — `N_SRC` — pending register.
- `mask` — out — `N_SRC` — enable mask; 1 = enabled.

## Operation
- **Edge detect.** `prev <= irq_src` every cycle. `edge = irq_src & ~prev`, which sets the matching `pending` bit. A source that is already pending absorbs further edges; there is no counting.
- **MASK write.** `mask <= cfg_wdata[N_SRC-1:0]`. Masked sources still latch into `pending` but never win arbitration.
- **CLRPEND write.** Clears the `pending` bits where `cfg_wdata` is 1. If a new edge and a clear hit the same bit in the same cycle, set wins.
- **Eligibility.** `elig = pending & mask`. The winner is the lowest eligible index (fixed priority).
- **FSM states.**
  - **IDLE**
    - `ExtIRQ` = 0.
    - If `elig != 0`: latch the winner into `cur_id` and go to REQ.
  - **REQ**
    - `ExtIRQ` = 1; `irq_id` = `cur_id`.
    - If `ExtIAck` = 1: clear `pending[cur_id]` and go to ACTIVE.
    - Else if `mask[cur_id]` = 0 (masked during the request): go to IDLE. `pending[cur_id]` is kept.
    - Else stay in REQ. The winner stays locked even if a higher-priority source becomes eligible.
  - **ACTIVE**
    - `ExtIRQ` = 0; `irq_id` holds `cur_id`.
    - An EOI write goes to IDLE. There is no nesting.
- EOI writes in IDLE or REQ are ignored. `ExtIAck` outside REQ is ignored.
- If an ack clear and a new edge hit the same bit in the same cycle, set wins: the source re-requests after EOI.

## Timing
- **Reset values.** `ExtIRQ` = 0, `irq_id` = 0, `pending` = 0, `mask` = 0 (all disabled), `prev` = 0, state = IDLE, round-robin pointer = 0.
- **Reset behaviour.** Reset asserted mid-handshake clears all state immediately; `ExtIRQ` drops asynchronously.
- `ExtIRQ` and `irq_id` are registered outputs decoded from state.
- **Request latency.** With the source rise sampled at edge k: `pending` is set after edge k, the FSM is in REQ and `ExtIRQ` = 1 after edge k+1.
- **Acknowledge.** `ExtIAck` sampled high at edge j gives `ExtIRQ` = 0 and `pending` cleared after edge j.
- **Back-to-back.** EOI sampled at edge e gives IDLE after e. The next `ExtIRQ` rises after e+1 if another source is eligible.
- **Write visibility.** A configuration write takes effect on the edge where `cfg_we` is sampled.

## Configuration
- **`IRQ_ROUND_ROBIN_EN` defined.** Arbitration is rotating: search starts at `(last_ack_id + 1) mod N_SRC`. `last_ack_id` updates on each ack.
- **`IRQ_ROUND_ROBIN_EN` undefined.** Fixed priority, index 0 highest; no pointer register is present.

## Structure
- **Package `irq_pkg`.**
  - State enum `irq_state_t` (IDLE, REQ, ACTIVE).
  - Register address constants `CFG_MASK`, `CFG_CLRPEND`, `CFG_EOI`.
  - Default `N_SRC`.
- **Sub-module `irq_prio_enc`.** Combinational; inputs `elig` and start index; outputs `found` and `id`. It implements both fixed and rotating search, so the top level holds only registers and the FSM.

## Test plan
- **Reset values.** `reset` = 0 mid-REQ → `ExtIRQ`, `pending`, and `mask` are 0 immediately; state is IDLE after release.
- **Single request.** MASK = 0xF, pulse `irq_src[2]` → `ExtIRQ` = 1 two edges later with `irq_id` = 2. Ack → `pending` = 0x0. EOI → IDLE.
- **Fixed priority.** `irq_src` = 0b1010 in the same cycle → `irq_id` = 1 first. After ack and EOI, `irq_id` = 3.
- **Masked source.** MASK = 0x0, pulse `irq_src[0]` → `pending` = 0x1 and `ExtIRQ` stays 0. MASK = 0x1 → `ExtIRQ` rises. Masking it again during REQ → IDLE with `pending` still 0x1.
- **Set-wins collisions.** A CLRPEND = 0x4 write in the same cycle as an edge on `irq_src[2]` → `pending[2]` = 1. EOI written while in REQ → ignored, state stays REQ.
- **Rotating priority (`IRQ_ROUND_ROBIN_EN`).** Sources 0 and 1 held continuously eligible (re-pulsed after each ack) → grants alternate 0, 1, 0, 1.
